// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Fills the instruction segment [BASE_ADDR, END_ADDR) of the byte-addressable
// RAM from a byte stream before the core is released from reset. Bytes are
// packed little-endian into 32-bit words and written with full-word writes.
// A trailing partial word is flushed with a halfword write, a byte write, or
// both, so no byte beyond the image length is ever written.
//
// Ports:
//   CLK         clock, all state updates on the rising edge
//   RST         synchronous active-low reset
//   start       begin a load (honoured only in IDLE or DONE)
//   s_valid     stream byte valid
//   s_ready     loader accepts a byte this cycle
//   s_data      stream byte
//   s_last      marks the final byte of the image
//   mem_addr    RAM byte address
//   mem_data    RAM write data
//   mem_w_en    RAM write enable
//   mem_sel     write mode: 00 word, 01 halfword, 10 byte
//   busy        load in progress (holds the core in reset)
//   done        load finished (level)
//   overflow    segment filled before s_last; sticky until next start
//   byte_count  bytes written in the current load
//
// Every output is a flop. The output flops are loaded from the decode of the
// next state, so each output equals the decode of the current state with no
// combinational path from the stream inputs.
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int BASE_ADDR     = 0,
    parameter int END_ADDR      = 128
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     start,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [7:0]               s_data,
    input  logic                     s_last,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_data,
    output logic                     mem_w_en,
    output logic [1:0]               mem_sel,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow,
    output logic [ADDRESS_WIDTH-1:0] byte_count
);

    localparam logic [1:0] SEL_WW = 2'b00;
    localparam logic [1:0] SEL_WH = 2'b01;
    localparam logic [1:0] SEL_WB = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RECV    = 3'd1,
        ST_WRITE_W = 3'd2,
        ST_FLUSH_H = 3'd3,
        ST_FLUSH_B = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // State registers
    state_t                   state_r;
    logic [ADDRESS_WIDTH-1:0] wr_addr_r;
    logic [31:0]              pack_buf_r;
    logic [1:0]               idx_r;
    logic                     last_seen_r;
    logic [ADDRESS_WIDTH-1:0] byte_count_r;
    logic                     overflow_r;

    // Registered outputs
    logic                     s_ready_r;
    logic                     busy_r;
    logic                     done_r;
    logic                     mem_w_en_r;
    logic [1:0]               mem_sel_r;
    logic [ADDRESS_WIDTH-1:0] mem_addr_r;
    logic [DATA_WIDTH-1:0]    mem_data_r;

    // Next-state values
    state_t                   nxt_state_s;
    logic [ADDRESS_WIDTH-1:0] nxt_wr_addr_s;
    logic [31:0]              nxt_buf_s;
    logic [1:0]               nxt_idx_s;
    logic                     nxt_last_s;
    logic [ADDRESS_WIDTH-1:0] nxt_count_s;
    logic                     nxt_ovf_s;

    // Output decode of the next state
    logic                     nxt_s_ready_s;
    logic                     nxt_busy_s;
    logic                     nxt_done_s;
    logic                     nxt_w_en_s;
    logic [1:0]               nxt_sel_s;
    logic [DATA_WIDTH-1:0]    nxt_data_s;

    // Next-state and datapath update rules of the loader FSM
    always_comb begin
        nxt_state_s   = state_r;
        nxt_wr_addr_s = wr_addr_r;
        nxt_buf_s     = pack_buf_r;
        nxt_idx_s     = idx_r;
        nxt_last_s    = last_seen_r;
        nxt_count_s   = byte_count_r;
        nxt_ovf_s     = overflow_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    nxt_state_s   = ST_RECV;
                    nxt_wr_addr_s = ADDRESS_WIDTH'(BASE_ADDR);
                    nxt_idx_s     = 2'd0;
                    nxt_count_s   = {ADDRESS_WIDTH{1'b0}};
                    nxt_ovf_s     = 1'b0;
                    nxt_last_s    = 1'b0;
                end else begin
                    nxt_state_s = state_r;
                end
            end
            ST_RECV: begin
                if (s_valid && s_ready_r) begin
                    nxt_buf_s[{idx_r, 3'b000} +: 8] = s_data;
                    nxt_last_s = s_last;
                    if (idx_r == 2'd3) begin
                        nxt_state_s = ST_WRITE_W;
                        nxt_idx_s   = 2'd0;
                    end else if (s_last) begin
                        // idx is kept so the flush states know the tail size
                        // (idx+1 pending bytes).
                        if (idx_r == 2'd0) begin
                            nxt_state_s = ST_FLUSH_B;
                        end else begin
                            nxt_state_s = ST_FLUSH_H;
                        end
                    end else begin
                        nxt_idx_s = idx_r + 2'd1;
                    end
                end else begin
                    nxt_state_s = ST_RECV;
                end
            end
            ST_WRITE_W: begin
                nxt_wr_addr_s = wr_addr_r + ADDRESS_WIDTH'(4);
                nxt_count_s   = byte_count_r + ADDRESS_WIDTH'(4);
                if (last_seen_r) begin
                    nxt_state_s = ST_DONE;
                end else if (wr_addr_r + ADDRESS_WIDTH'(4) == ADDRESS_WIDTH'(END_ADDR)) begin
                    nxt_state_s = ST_DONE;
                    nxt_ovf_s   = 1'b1;
                end else begin
                    nxt_state_s = ST_RECV;
                end
            end
            ST_FLUSH_H: begin
                nxt_count_s = byte_count_r + ADDRESS_WIDTH'(2);
                if (idx_r == 2'd2) begin
                    // 3-byte tail: the third byte follows as a byte write.
                    nxt_state_s   = ST_FLUSH_B;
                    nxt_wr_addr_s = wr_addr_r + ADDRESS_WIDTH'(2);
                end else begin
                    nxt_state_s = ST_DONE;
                end
            end
            ST_FLUSH_B: begin
                nxt_count_s = byte_count_r + ADDRESS_WIDTH'(1);
                nxt_state_s = ST_DONE;
            end
            default: begin
                nxt_state_s = ST_IDLE;
            end
        endcase
    end

    // Output values that the next state presents
    always_comb begin
        nxt_s_ready_s = 1'b0;
        nxt_busy_s    = 1'b0;
        nxt_done_s    = 1'b0;
        nxt_w_en_s    = 1'b0;
        nxt_sel_s     = SEL_WW;
        nxt_data_s    = {DATA_WIDTH{1'b0}};
        case (nxt_state_s)
            ST_IDLE: begin
                nxt_busy_s = 1'b0;
            end
            ST_RECV: begin
                nxt_s_ready_s = 1'b1;
                nxt_busy_s    = 1'b1;
            end
            ST_WRITE_W: begin
                nxt_busy_s = 1'b1;
                nxt_w_en_s = 1'b1;
                nxt_sel_s  = SEL_WW;
                nxt_data_s = DATA_WIDTH'(nxt_buf_s);
            end
            ST_FLUSH_H: begin
                nxt_busy_s = 1'b1;
                nxt_w_en_s = 1'b1;
                nxt_sel_s  = SEL_WH;
                nxt_data_s = DATA_WIDTH'({16'h0000, nxt_buf_s[15:0]});
            end
            ST_FLUSH_B: begin
                nxt_busy_s = 1'b1;
                nxt_w_en_s = 1'b1;
                nxt_sel_s  = SEL_WB;
                // 1-byte tail sits in lane 0, the third byte of a 3-byte tail in lane 2.
                if (nxt_idx_s == 2'd0) begin
                    nxt_data_s = DATA_WIDTH'({24'h000000, nxt_buf_s[7:0]});
                end else begin
                    nxt_data_s = DATA_WIDTH'({24'h000000, nxt_buf_s[23:16]});
                end
            end
            ST_DONE: begin
                nxt_done_s = 1'b1;
            end
            default: begin
                nxt_busy_s = 1'b0;
            end
        endcase
    end

    // State and registered-output flops with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_r      <= ST_IDLE;
            wr_addr_r    <= {ADDRESS_WIDTH{1'b0}};
            pack_buf_r   <= 32'h0000_0000;
            idx_r        <= 2'd0;
            last_seen_r  <= 1'b0;
            byte_count_r <= {ADDRESS_WIDTH{1'b0}};
            overflow_r   <= 1'b0;
            s_ready_r    <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            mem_w_en_r   <= 1'b0;
            mem_sel_r    <= SEL_WW;
            mem_addr_r   <= {ADDRESS_WIDTH{1'b0}};
            mem_data_r   <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r      <= nxt_state_s;
            wr_addr_r    <= nxt_wr_addr_s;
            pack_buf_r   <= nxt_buf_s;
            idx_r        <= nxt_idx_s;
            last_seen_r  <= nxt_last_s;
            byte_count_r <= nxt_count_s;
            overflow_r   <= nxt_ovf_s;
            s_ready_r    <= nxt_s_ready_s;
            busy_r       <= nxt_busy_s;
            done_r       <= nxt_done_s;
            mem_w_en_r   <= nxt_w_en_s;
            mem_sel_r    <= nxt_sel_s;
            mem_addr_r   <= nxt_wr_addr_s;
            mem_data_r   <= nxt_data_s;
        end
    end

    assign s_ready    = s_ready_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign mem_w_en   = mem_w_en_r;
    assign mem_sel    = mem_sel_r;
    assign mem_addr   = mem_addr_r;
    assign mem_data   = mem_data_r;
    assign overflow   = overflow_r;
    assign byte_count = byte_count_r;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader. Each load drives an image (optionally
// with random valid gaps and stray start pulses) and compares every RAM write
// and the final status against a reference model that derives the write list
// directly from the image bytes: whole words first, then the 1/2/3-byte tail.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BASE = 0;
    localparam int ENDA = 128;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  sel;
    } wr_t;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          start = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [7:0]    s_data = 8'h00;
    logic          s_last = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_w_en;
    logic [1:0]    mem_sel;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [AW-1:0] byte_count;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  img[$];
    wr_t         obs_q[$];
    wr_t         exp_q[$];
    int          exp_bc;
    logic        exp_ov;

    imem_loader #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW),
        .BASE_ADDR    (BASE),
        .END_ADDR     (ENDA)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_w_en  (mem_w_en),
        .mem_sel   (mem_sel),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .byte_count(byte_count)
    );

    always #5 CLK = ~CLK;

    // Record every RAM write, sampled away from the active edge
    always @(negedge CLK) begin
        if (mem_w_en) begin
            obs_q.push_back('{addr: mem_addr, data: mem_data, sel: mem_sel});
        end
    end

    // Global watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Reference: the image (truncated to the segment when no last byte fits)
    // becomes whole little-endian words, then a halfword and/or byte tail.
    task automatic build_exp(input int n, input bit has_last);
        int cap;
        int len;
        int r;
        int q;
        cap = ENDA - BASE;
        exp_q.delete();
        if (has_last && n <= cap) begin
            len    = n;
            exp_ov = 1'b0;
        end else begin
            len    = cap;
            exp_ov = 1'b1;
        end
        for (int w = 0; w + 4 <= len; w += 4) begin
            exp_q.push_back('{addr: 32'(BASE + w),
                              data: {img[w+3], img[w+2], img[w+1], img[w]},
                              sel: 2'b00});
        end
        r = len % 4;
        q = len - r;
        if (r >= 2) begin
            exp_q.push_back('{addr: 32'(BASE + q), data: {16'h0000, img[q+1], img[q]}, sel: 2'b01});
        end
        if (r == 1) begin
            exp_q.push_back('{addr: 32'(BASE + q), data: {24'h000000, img[q]}, sel: 2'b10});
        end
        if (r == 3) begin
            exp_q.push_back('{addr: 32'(BASE + q + 2), data: {24'h000000, img[q+2]}, sel: 2'b10});
        end
        exp_bc = len;
    endtask

    task automatic run_load(input string name, input int n, input bit has_last,
                            input bit gaps, input bit noise);
        int  i;
        int  cyc;
        int  w;
        int  nchk;
        bit  acc;
        build_exp(n, has_last);
        @(negedge CLK);
        obs_q.delete();
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        check_val({name, "_start_count"}, 64'(byte_count), 64'd0);
        check_val({name, "_start_flags"}, 64'({busy, s_ready, done, overflow}), 64'b1100);
        i   = 0;
        cyc = 0;
        while (i < n && cyc < n * 8 + 64) begin
            @(negedge CLK);
            cyc++;
            start   = 1'b0;
            s_valid = 1'b0;
            if (done) break;
            if (gaps && $urandom_range(0, 2) == 0) begin
                s_data = 8'($urandom);
                s_last = 1'($urandom);
            end else begin
                s_valid = 1'b1;
                s_data  = img[i];
                s_last  = has_last && (i == n - 1);
            end
            if (noise) start = ($urandom_range(0, 3) == 0);
            acc = s_valid && s_ready;
            @(posedge CLK);
            if (acc) i++;
        end
        @(negedge CLK);
        start   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        w = 0;
        while (!done && w < 40) begin
            @(negedge CLK);
            w++;
        end
        check_val({name, "_done"}, 64'(done), 64'd1);
        repeat (2) @(negedge CLK);
        check_val({name, "_nwrites"}, 64'(obs_q.size()), 64'(exp_q.size()));
        nchk = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int k = 0; k < nchk; k++) begin
            check_val($sformatf("%s_w%0d_addr", name, k), 64'(obs_q[k].addr), 64'(exp_q[k].addr));
            check_val($sformatf("%s_w%0d_data", name, k), 64'(obs_q[k].data), 64'(exp_q[k].data));
            check_val($sformatf("%s_w%0d_sel", name, k), 64'(obs_q[k].sel), 64'(exp_q[k].sel));
        end
        check_val({name, "_byte_count"}, 64'(byte_count), 64'(exp_bc));
        check_val({name, "_overflow"}, 64'(overflow), 64'(exp_ov));
        check_val({name, "_end_flags"}, 64'({busy, s_ready, done, mem_w_en}), 64'b0010);
    endtask

    initial begin
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check_val("reset_flags", 64'({s_ready, busy, done, overflow, mem_w_en}), 64'd0);
        check_val("reset_addr", 64'(mem_addr), 64'd0);
        check_val("reset_count", 64'(byte_count), 64'd0);

        // Eight bytes, two full words
        img.delete();
        for (int k = 0; k < 8; k++) img.push_back(8'(8'h11 * (k + 1)));
        run_load("eight", 8, 1'b1, 1'b0, 1'b0);

        // Three-byte image: halfword then byte
        img.delete();
        img.push_back(8'hAA); img.push_back(8'hBB); img.push_back(8'hCC);
        run_load("three", 3, 1'b1, 1'b0, 1'b0);

        // Single byte
        img.delete();
        img.push_back(8'h5A);
        run_load("one", 1, 1'b1, 1'b0, 1'b0);

        // Overflow: more bytes than the segment, no last
        img.delete();
        for (int k = 0; k < 130; k++) img.push_back(8'($urandom));
        run_load("ovf", 130, 1'b0, 1'b0, 1'b0);

        // Reset mid-load after two accepted bytes
        @(negedge CLK);
        obs_q.delete();
        start = 1'b1;
        @(negedge CLK);
        start   = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h01;
        @(negedge CLK);
        s_data = 8'h02;
        @(negedge CLK);
        s_valid = 1'b0;
        RST     = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        check_val("midrst_flags", 64'({s_ready, busy, done, overflow, mem_w_en}), 64'd0);
        check_val("midrst_addr", 64'(mem_addr), 64'd0);
        check_val("midrst_data", 64'(mem_data), 64'd0);
        check_val("midrst_count", 64'(byte_count), 64'd0);
        repeat (3) @(negedge CLK);
        check_val("midrst_nwrites", 64'(obs_q.size()), 64'd0);
        check_val("midrst_idle", 64'({busy, done}), 64'd0);

        // Fresh load after reset
        img.delete();
        for (int k = 0; k < 6; k++) img.push_back(8'($urandom));
        run_load("postrst", 6, 1'b1, 1'b0, 1'b0);

        // Random images with valid gaps and stray start pulses
        for (int t = 0; t < 8; t++) begin
            int n;
            n = (t == 7) ? 128 : $urandom_range(1, 40);
            img.delete();
            for (int k = 0; k < n; k++) img.push_back(8'($urandom));
            run_load($sformatf("rnd%0d", t), n, 1'b1, 1'b1, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
